fluxo_dados_jogo: RTL and testbench

FLUXO_DADOS_JOGO -- requirements
Module: fluxo_dados_jogo

---
 rtl/fluxo_dados_jogo.sv | 103 ++++++++++
 tb/tb_fluxo_dados_jogo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fluxo_dados_jogo.sv
// Datapath for the memory game: address/round/timeout counters, jogada register,
// pattern ROM and a one-pulse-per-press button edge detector.
module fluxo_dados_jogo #(
  parameter int TIMEOUT = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       zeraE,
  input  logic       contaE,
  input  logic       zeraRod,
  input  logic       contaRod,
  input  logic       zeraT,
  input  logic       contaT,
  input  logic       zeraR,
  input  logic       registraR,
  output logic       igual,
  output logic       enderecoIgualRodada,
  output logic       fimE,
  output logic       fimRod,
  output logic       fimT,
  output logic       jogada_feita,
  output logic [3:0] db_contagem,
  output logic [3:0] db_rodada,
  output logic [3:0] db_jogada,
  output logic [3:0] db_memoria
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  logic [3:0]    contE;
  logic [3:0]    contRod;
  logic [TW-1:0] contT;
  logic [3:0]    jogadaReg;
  logic [3:0]    romWord;
  logic          anyPressed;
  logic          anyPrev;

  assign anyPressed = |botoes;

  // Reset (active-low) dominates every clear, and each clear dominates its count/load.
  always_ff @(posedge clock) begin
    if (!reset) begin
      contE     <= '0;
      contRod   <= '0;
      contT     <= '0;
      jogadaReg <= '0;
      anyPrev   <= 1'b0;
    end else begin
      anyPrev <= anyPressed;

      if (zeraE)       contE <= '0;
      else if (contaE) contE <= contE + 4'd1;

      if (zeraRod)       contRod <= '0;
      else if (contaRod) contRod <= contRod + 4'd1;

      // Timeout counter saturates so fimT stays asserted until cleared.
      if (zeraT)                        contT <= '0;
      else if (contaT && contT != TMAX) contT <= contT + 1'b1;

      if (zeraR)          jogadaReg <= '0;
      else if (registraR) jogadaReg <= botoes;
    end
  end

  always_comb begin
    romWord = 4'b0000;
    case (contE)
      4'd0:    romWord = 4'b0001;
      4'd1:    romWord = 4'b0010;
      4'd2:    romWord = 4'b0100;
      4'd3:    romWord = 4'b1000;
      4'd4:    romWord = 4'b0100;
      4'd5:    romWord = 4'b0010;
      4'd6:    romWord = 4'b0001;
      4'd7:    romWord = 4'b0001;
      4'd8:    romWord = 4'b0010;
      4'd9:    romWord = 4'b0010;
      4'd10:   romWord = 4'b0100;
      4'd11:   romWord = 4'b0100;
      4'd12:   romWord = 4'b1000;
      4'd13:   romWord = 4'b1000;
      4'd14:   romWord = 4'b0001;
      4'd15:   romWord = 4'b0100;
      default: romWord = 4'b0000;
    endcase
  end

  assign igual               = (romWord == jogadaReg);
  assign enderecoIgualRodada = (contE == contRod);
  assign fimE                = (contE == 4'd15);
  assign fimRod              = (contRod == 4'd15);
  assign fimT                = (contT == TMAX);
  assign jogada_feita        = anyPressed & ~anyPrev;

  assign db_contagem = contE;
  assign db_rodada   = contRod;
  assign db_jogada   = jogadaReg;
  assign db_memoria  = romWord;

endmodule

// File: tb/tb_fluxo_dados_jogo.sv
// Directed bench for fluxo_dados_jogo with TIMEOUT=8; expected values are hand-computed.
module tb_fluxo_dados_jogo;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] botoes;
  logic       zeraE, contaE, zeraRod, contaRod, zeraT, contaT, zeraR, registraR;
  logic       igual, enderecoIgualRodada, fimE, fimRod, fimT, jogada_feita;
  logic [3:0] db_contagem, db_rodada, db_jogada, db_memoria;

  int vectors    = 0;
  int miscompares = 0;
  int pulses     = 0;

  fluxo_dados_jogo #(.TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .botoes(botoes),
    .zeraE(zeraE), .contaE(contaE), .zeraRod(zeraRod), .contaRod(contaRod),
    .zeraT(zeraT), .contaT(contaT), .zeraR(zeraR), .registraR(registraR),
    .igual(igual), .enderecoIgualRodada(enderecoIgualRodada), .fimE(fimE),
    .fimRod(fimRod), .fimT(fimT), .jogada_feita(jogada_feita),
    .db_contagem(db_contagem), .db_rodada(db_rodada),
    .db_jogada(db_jogada), .db_memoria(db_memoria)
  );

  always #5 clock = ~clock;

  // One rising edge, then settle 1 time unit past it.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_E"},      16'(db_contagem), 16'h0);
    checkOutput({tag, "_Rod"},    16'(db_rodada), 16'h0);
    checkOutput({tag, "_jog"},    16'(db_jogada), 16'h0);
    checkOutput({tag, "_mem"},    16'(db_memoria), 16'h1);
    checkOutput({tag, "_igual"},  16'(igual), 16'h0);
    checkOutput({tag, "_eqRod"},  16'(enderecoIgualRodada), 16'h1);
    checkOutput({tag, "_fimE"},   16'(fimE), 16'h0);
    checkOutput({tag, "_fimRod"}, 16'(fimRod), 16'h0);
    checkOutput({tag, "_fimT"},   16'(fimT), 16'h0);
    checkOutput({tag, "_pulse"},  16'(jogada_feita), 16'h0);
  endtask

  logic [3:0] pressSeq [11] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h3, 4'h3, 4'h0, 4'h8, 4'h8};
  logic       pulseExp [11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    botoes = 4'h0;
    {zeraE, contaE, zeraRod, contaRod, zeraT, contaT, zeraR, registraR} = '0;
    reset = 1'b0;
    applyStimulus(2);
    checkResetState("reset");
    reset = 1'b1;

    // E counts to 3: ROM[3]=1000, no longer equal to Rod=0
    contaE = 1'b1;
    applyStimulus(3);
    contaE = 1'b0;
    checkOutput("E3_cont",  16'(db_contagem), 16'h3);
    checkOutput("E3_mem",   16'(db_memoria), 16'h8);
    checkOutput("E3_eqRod", 16'(enderecoIgualRodada), 16'h0);

    // Full wrap of E with fimE only at 15
    zeraE = 1'b1;
    applyStimulus(1);
    zeraE = 1'b0;
    contaE = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("wrap_E%0d", i), 16'(db_contagem), 16'(i % 16));
      checkOutput($sformatf("wrap_fimE%0d", i), 16'(fimE), (i == 15) ? 16'h1 : 16'h0);
    end
    applyStimulus(1);
    checkOutput("E_before_zera", 16'(db_contagem), 16'h1);
    zeraE = 1'b1;
    applyStimulus(1);
    zeraE = 1'b0;
    contaE = 1'b0;
    checkOutput("zeraE_prio", 16'(db_contagem), 16'h0);

    // E=2 compare against jogada register
    contaE = 1'b1;
    applyStimulus(2);
    contaE = 1'b0;
    botoes = 4'b0100;
    registraR = 1'b1;
    applyStimulus(1);
    registraR = 1'b0;
    checkOutput("jog_0100", 16'(db_jogada), 16'h4);
    checkOutput("igual_hit", 16'(igual), 16'h1);
    botoes = 4'b0010;
    registraR = 1'b1;
    applyStimulus(1);
    checkOutput("jog_0010", 16'(db_jogada), 16'h2);
    checkOutput("igual_miss", 16'(igual), 16'h0);
    zeraR = 1'b1;
    applyStimulus(1);
    zeraR = 1'b0;
    registraR = 1'b0;
    botoes = 4'b0000;
    checkOutput("zeraR_prio", 16'(db_jogada), 16'h0);

    // Timeout saturation at TIMEOUT-1 = 7
    zeraT = 1'b1;
    applyStimulus(1);
    zeraT = 1'b0;
    contaT = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("fimT_%0d", i), 16'(fimT), (i >= 7) ? 16'h1 : 16'h0);
    end
    zeraT = 1'b1;
    applyStimulus(1);
    zeraT = 1'b0;
    contaT = 1'b0;
    checkOutput("fimT_cleared", 16'(fimT), 16'h0);

    // Button edge detector: held, widened and re-pressed
    for (int i = 0; i < 11; i++) begin
      botoes = pressSeq[i];
      #1;
      if (jogada_feita === 1'b1) pulses++;
      checkOutput($sformatf("pulse_%0d", i), 16'(jogada_feita), 16'(pulseExp[i]));
      applyStimulus(1);
    end
    botoes = 4'b0000;
    checkOutput("pulse_total", 16'(pulses), 16'd2);

    // Rod and E both at 5
    zeraE = 1'b1;
    zeraRod = 1'b1;
    applyStimulus(1);
    zeraE = 1'b0;
    zeraRod = 1'b0;
    contaE = 1'b1;
    contaRod = 1'b1;
    applyStimulus(5);
    contaE = 1'b0;
    checkOutput("rod5",     16'(db_rodada), 16'h5);
    checkOutput("e5",       16'(db_contagem), 16'h5);
    checkOutput("eqRod55",  16'(enderecoIgualRodada), 16'h1);
    checkOutput("mem5",     16'(db_memoria), 16'h2);
    applyStimulus(10);
    checkOutput("rod15_fim", 16'(fimRod), 16'h1);
    checkOutput("eqRod_ne",  16'(enderecoIgualRodada), 16'h0);
    zeraRod = 1'b1;
    applyStimulus(1);
    zeraRod = 1'b0;
    checkOutput("zeraRod_prio", 16'(db_rodada), 16'h0);

    // Mid-count reset overrides every count and load
    applyStimulus(3);
    contaE = 1'b1;
    contaT = 1'b1;
    registraR = 1'b1;
    botoes = 4'b1000;
    applyStimulus(2);
    checkOutput("prereset_rod", 16'(db_rodada), 16'h5);
    reset = 1'b0;
    applyStimulus(1);
    botoes = 4'b0000;
    #1;
    checkResetState("midreset");
    {contaE, contaRod, contaT, registraR} = '0;
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("post_reset_hold", 16'(db_rodada), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
